// File: rtl/irq_controller_pkg.sv
// Shared types and helpers for the prioritised, nesting interrupt controller.
// The priority encoder works on a MAX_IRQ-wide vector; narrower vectors are zero-extended.
package irq_controller_pkg;

  localparam int unsigned MAX_IRQ = 16;
  localparam int unsigned IDX_W = 5;
  // One past the highest channel: ranks below every real index, so "nothing set" never wins.
  localparam logic [IDX_W-1:0] IDX_NONE = 5'd16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irq_state_t;

  function automatic int unsigned irq_id_width(int unsigned num_irq);
    return (num_irq <= 1) ? 1 : $clog2(num_irq);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set_index(logic [MAX_IRQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = IDX_NONE;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt channel: multi-flop synchroniser followed by a prev register for edge detection.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic src,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  // prev resets low, so a line already high at reset release reads as a rising edge.
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: pending latch, in-service nesting stack and request FSM
// that holds one committed request towards controlpath until it is acknowledged.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned        NUM_IRQ       = 8,
  parameter int unsigned        ADDR_W        = 16,
  parameter logic [ADDR_W-1:0]  VECTOR_BASE   = 16'hFF00,
  parameter int unsigned        VECTOR_STRIDE = 2,
  parameter int unsigned        SYNC_STAGES   = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_IRQ-1:0]                irq_src,
  input  logic [NUM_IRQ-1:0]                irq_edge_mode,
  input  logic [NUM_IRQ-1:0]                irq_mask,
  input  logic                              global_enable,
  input  logic                              irq_ack,
  input  logic                              irq_eoi,
  output logic                              irq,
  output logic [ADDR_W-1:0]                 irq_vector,
  output logic [irq_id_width(NUM_IRQ)-1:0]  irq_id,
  output logic [NUM_IRQ-1:0]                pending,
  output logic [NUM_IRQ-1:0]                in_service
);

  localparam int unsigned IRQ_ID_W = irq_id_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] sync_level;
  logic [NUM_IRQ-1:0] sync_rise;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clock (clock),
      .reset (reset),
      .src   (irq_src[g]),
      .level (sync_level[g]),
      .rise  (sync_rise[g])
    );
  end

  irq_state_t          state_q, state_d;
  logic [NUM_IRQ-1:0]  edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0]  in_service_q, in_service_d;
  logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;
  logic [ADDR_W-1:0]   irq_vector_q, irq_vector_d;

  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  id_onehot;
  logic [NUM_IRQ-1:0]  ack_clr;
  logic [NUM_IRQ-1:0]  is_lowest_bit;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    is_idx;
  logic                accept;
  logic                ack_fire;

  always_comb begin
    pending  = (edge_pend_q & irq_edge_mode) | (sync_level & ~irq_edge_mode);
    eligible = pending & irq_mask & {NUM_IRQ{global_enable}};
    win_idx  = lowest_set_index(MAX_IRQ'(eligible));
    is_idx   = lowest_set_index(MAX_IRQ'(in_service_q));
    // IDX_NONE exceeds every real index, so an empty in-service set admits any winner.
    accept   = (win_idx < is_idx);
    ack_fire = (state_q == REQ) && irq_ack;

    id_onehot = NUM_IRQ'(1) << irq_id_q;
    ack_clr   = ack_fire ? id_onehot : '0;

    // Set wins over a coincident ack clear.
    edge_pend_d = (edge_pend_q & ~ack_clr) | (sync_rise & irq_edge_mode);

    is_lowest_bit = in_service_q & (~in_service_q + NUM_IRQ'(1));
    in_service_d  = in_service_q;
    if (irq_eoi) in_service_d = in_service_d & ~is_lowest_bit;
    if (ack_fire) in_service_d = in_service_d | id_onehot;
  end

  always_comb begin
    state_d      = state_q;
    irq_id_d     = irq_id_q;
    irq_vector_d = irq_vector_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          irq_id_d     = IRQ_ID_W'(win_idx);
          irq_vector_d = VECTOR_BASE + ADDR_W'(win_idx) * ADDR_W'(VECTOR_STRIDE);
          state_d      = REQ;
        end
      end
      REQ: begin
        // Committed: only an ack retires the request.
        if (irq_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      edge_pend_q  <= '0;
      in_service_q <= '0;
      irq_id_q     <= '0;
      irq_vector_q <= VECTOR_BASE;
    end else begin
      state_q      <= state_d;
      edge_pend_q  <= edge_pend_d;
      in_service_q <= in_service_d;
      irq_id_q     <= irq_id_d;
      irq_vector_q <= irq_vector_d;
    end
  end

  assign irq        = (state_q == REQ);
  assign irq_id     = irq_id_q;
  assign irq_vector = irq_vector_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with default parameters (8 channels, base FF00, stride 2).
module tb_irq_controller;

  logic       clock;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] irq_edge_mode;
  logic [7:0] irq_mask;
  logic       global_enable;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq;
  logic [15:0] irq_vector;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] in_service;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller dut (
    .clock         (clock),
    .reset         (reset),
    .irq_src       (irq_src),
    .irq_edge_mode (irq_edge_mode),
    .irq_mask      (irq_mask),
    .global_enable (global_enable),
    .irq_ack       (irq_ack),
    .irq_eoi       (irq_eoi),
    .irq           (irq),
    .irq_vector    (irq_vector),
    .irq_id        (irq_id),
    .pending       (pending),
    .in_service    (in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and settle 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    irq_eoi = 1'b1;
    tick(1);
    irq_eoi = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic [2:0] id, input logic [15:0] vec);
    check({tag, "_irq"}, 32'(irq), 32'(1));
    check({tag, "_id"}, 32'(irq_id), 32'(id));
    check({tag, "_vec"}, 32'(irq_vector), 32'(vec));
  endtask

  initial begin
    reset = 1'b1;
    irq_src = '0;
    irq_edge_mode = '0;
    irq_mask = '0;
    global_enable = 1'b0;
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_irq", 32'(irq), 32'(0));
    check("rst_vec", 32'(irq_vector), 32'h0000_FF00);
    check("rst_id", 32'(irq_id), 32'(0));
    check("rst_pending", 32'(pending), 32'(0));
    check("rst_in_service", 32'(in_service), 32'(0));

    // Basic edge request on channel 3.
    global_enable = 1'b1;
    irq_mask = 8'hFF;
    irq_edge_mode = 8'hFF;
    irq_src = 8'h08;
    tick(2);
    check("edge_pend_early", 32'(pending), 32'(0));
    tick(1);
    check("edge_pend", 32'(pending), 32'h08);
    check("edge_no_irq_yet", 32'(irq), 32'(0));
    tick(1);
    check_req("edge_req", 3'd3, 16'hFF06);
    pulse_ack();
    check("edge_ack_irq", 32'(irq), 32'(0));
    check("edge_ack_pend", 32'(pending), 32'(0));
    check("edge_ack_is", 32'(in_service), 32'h08);
    pulse_eoi();
    check("edge_eoi_is", 32'(in_service), 32'(0));
    irq_src = 8'h00;
    tick(3);

    // Simultaneous sources 5 and 2.
    irq_src = 8'h24;
    tick(4);
    check_req("simul_first", 3'd2, 16'hFF04);
    pulse_ack();
    check("simul_ack_is", 32'(in_service), 32'h04);
    check("simul_pend5", 32'(pending), 32'h20);
    tick(1);
    check("simul_blocked", 32'(irq), 32'(0));
    pulse_eoi();
    check("simul_eoi_irq", 32'(irq), 32'(0));
    tick(1);
    check_req("simul_second", 3'd5, 16'hFF0A);
    // ack and eoi together: eoi sees empty in_service, ack sets bit 5.
    irq_eoi = 1'b1;
    pulse_ack();
    irq_eoi = 1'b0;
    check("ack_eoi_same", 32'(in_service), 32'h20);
    pulse_eoi();
    check("simul_done_is", 32'(in_service), 32'(0));
    irq_src = 8'h00;
    tick(3);

    // Nesting under channel 4.
    irq_src = 8'h10;
    tick(4);
    check_req("nest_ch4", 3'd4, 16'hFF08);
    pulse_ack();
    check("nest_is4", 32'(in_service), 32'h10);
    irq_src = 8'h50;
    tick(5);
    check("nest_ch6_pend", 32'(pending), 32'h40);
    check("nest_ch6_blocked", 32'(irq), 32'(0));
    irq_src = 8'h52;
    tick(4);
    check_req("nest_ch1", 3'd1, 16'hFF02);
    pulse_ack();
    check("nest_is12", 32'(in_service), 32'h12);
    pulse_eoi();
    check("nest_eoi1", 32'(in_service), 32'h10);
    check("nest_eoi1_irq", 32'(irq), 32'(0));
    pulse_eoi();
    check("nest_eoi2", 32'(in_service), 32'h00);
    tick(1);
    check_req("nest_ch6", 3'd6, 16'hFF0C);
    pulse_ack();
    pulse_eoi();
    check("nest_done_is", 32'(in_service), 32'(0));
    irq_src = 8'h00;
    tick(3);

    // Level mode on channel 0.
    irq_edge_mode = 8'hFE;
    irq_src = 8'h01;
    tick(4);
    check_req("lvl_req", 3'd0, 16'hFF00);
    pulse_ack();
    check("lvl_ack_pend", 32'(pending), 32'h01);
    check("lvl_ack_is", 32'(in_service), 32'h01);
    tick(2);
    check("lvl_no_rereq", 32'(irq), 32'(0));
    pulse_eoi();
    check("lvl_eoi_is", 32'(in_service), 32'(0));
    tick(1);
    check_req("lvl_rereq", 3'd0, 16'hFF00);
    irq_src = 8'h00;
    pulse_ack();
    pulse_eoi();
    tick(3);
    check("lvl_drop_pend", 32'(pending), 32'(0));
    check("lvl_drop_irq", 32'(irq), 32'(0));
    irq_edge_mode = 8'hFF;

    // Masking retains pending; unmask produces the request.
    irq_mask = 8'hFB;
    irq_src = 8'h04;
    tick(6);
    check("mask_irq", 32'(irq), 32'(0));
    check("mask_pend", 32'(pending), 32'h04);
    irq_mask = 8'hFF;
    tick(1);
    check_req("unmask_req", 3'd2, 16'hFF04);
    // Commitment: withdrawing enable, mask and source must not drop the request.
    global_enable = 1'b0;
    irq_mask = 8'h00;
    irq_src = 8'h00;
    tick(3);
    check_req("commit_hold", 3'd2, 16'hFF04);
    pulse_ack();
    check("commit_ack_irq", 32'(irq), 32'(0));
    check("commit_ack_is", 32'(in_service), 32'h04);
    pulse_eoi();
    global_enable = 1'b1;
    irq_mask = 8'hFF;

    // Ack while idle is ignored.
    pulse_ack();
    check("idle_ack_is", 32'(in_service), 32'(0));
    check("idle_ack_irq", 32'(irq), 32'(0));

    // Reset in the middle of a nested request.
    irq_src = 8'h80;
    tick(4);
    check_req("rmid_ch7", 3'd7, 16'hFF0E);
    pulse_ack();
    irq_src = 8'h81;
    tick(4);
    check_req("rmid_ch0", 3'd0, 16'hFF00);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_irq", 32'(irq), 32'(0));
    check("rmid_pend", 32'(pending), 32'(0));
    check("rmid_is", 32'(in_service), 32'(0));
    check("rmid_vec", 32'(irq_vector), 32'h0000_FF00);
    #1;
    reset = 1'b0;
    // Lines still high at reset release are seen as fresh rising edges.
    tick(3);
    check("post_rst_pend", 32'(pending), 32'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
